// File: rtl/sdfa_pkg.sv
// rtl/sdfa_pkg.sv - shared constants and FSM state type for the SDFA result decoder
package sdfa_pkg;

  localparam int NUM_CLASS_DEFAULT = 10;
  localparam int LABEL_W = 4;
  localparam logic [LABEL_W-1:0] NO_SPIKE_LABEL = 4'hF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sdfa_label_fifo.sv
// rtl/sdfa_label_fifo.sv - synchronous reference-label FIFO with full/empty flags
module sdfa_label_fifo
  import sdfa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = LABEL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sdfa_result_decoder.sv
// rtl/sdfa_result_decoder.sv - spike-frame to class decoder with label check and stats
// Optional statistics counters are built when SDFA_RESULT_STATS_EN is defined.
module sdfa_result_decoder
  import sdfa_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEFAULT,
  parameter int LBL_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               result_spike,
  input  logic               result_spike_valid,
  input  logic [LABEL_W-1:0] label_in,
  input  logic               label_valid,
  output logic               label_ready,
  input  logic               stats_clr,
  output logic [LABEL_W-1:0] pred_label,
  output logic               pred_valid,
  output logic               pred_multi,
  output logic               pred_correct,
  output logic               label_miss,
  output logic               frame_err,
  output logic [CNT_W-1:0]   img_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int IDX_W = $clog2(NUM_CLASS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  dec_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [NUM_CLASS-1:0] spikes;
  logic [NUM_CLASS-1:0] frame_vec;
  logic                 report;
  logic [LABEL_W-1:0]   dec_label;
  logic                 dec_multi;
  logic                 seen;
  logic [LABEL_W-1:0]   fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 hit;

  // Bits shift in from the top, so after NUM_CLASS samples class 0 sits at bit 0.
  assign frame_vec   = {result_spike, spikes[NUM_CLASS-1:1]};
  assign report      = (state == ST_COLLECT) && result_spike_valid && (idx == LAST_IDX);
  assign hit         = !fifo_empty && (fifo_head == dec_label);
  assign label_ready = !fifo_full;

  always_comb begin
    dec_label = NO_SPIKE_LABEL;
    dec_multi = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (frame_vec[i]) begin
        if (!seen) dec_label = LABEL_W'(i);
        else       dec_multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  sdfa_label_fifo #(
    .DEPTH (LBL_DEPTH),
    .W     (LABEL_W)
  ) u_label_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (label_valid),
    .push_data (label_in),
    .pop       (report),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      spikes       <= '0;
      pred_label   <= NO_SPIKE_LABEL;
      pred_valid   <= 1'b0;
      pred_multi   <= 1'b0;
      pred_correct <= 1'b0;
      label_miss   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (result_spike_valid) spikes <= frame_vec;
      case (state)
        ST_IDLE: begin
          if (result_spike_valid) begin
            state <= ST_COLLECT;
            idx   <= IDX_W'(1);
          end
        end
        ST_COLLECT: begin
          if (!result_spike_valid) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
            idx       <= '0;
          end else if (idx == LAST_IDX) begin
            // Returning to IDLE lets a still-high valid start the next frame at class 0.
            state        <= ST_IDLE;
            idx          <= '0;
            pred_valid   <= 1'b1;
            pred_label   <= dec_label;
            pred_multi   <= dec_multi;
            pred_correct <= hit;
            label_miss   <= fifo_empty;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SDFA_RESULT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_count <= '0;
      err_count <= '0;
    end else if (stats_clr) begin
      img_count <= '0;
      err_count <= '0;
    end else if (report) begin
      if (img_count != '1)         img_count <= img_count + 1'b1;
      if (!hit && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign img_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sdfa_result_decoder.sv
// tb/tb_sdfa_result_decoder.sv - table-driven scoreboard bench for sdfa_result_decoder
module tb_sdfa_result_decoder;

`ifdef SDFA_RESULT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        result_spike = 1'b0;
  logic        result_spike_valid = 1'b0;
  logic [3:0]  label_in = 4'h0;
  logic        label_valid = 1'b0;
  logic        label_ready;
  logic        stats_clr = 1'b0;
  logic [3:0]  pred_label;
  logic        pred_valid;
  logic        pred_multi;
  logic        pred_correct;
  logic        label_miss;
  logic        frame_err;
  logic [15:0] img_count;
  logic [15:0] err_count;

  sdfa_result_decoder #(.NUM_CLASS(10), .LBL_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .result_spike(result_spike), .result_spike_valid(result_spike_valid),
    .label_in(label_in), .label_valid(label_valid), .label_ready(label_ready),
    .stats_clr(stats_clr), .pred_label(pred_label), .pred_valid(pred_valid),
    .pred_multi(pred_multi), .pred_correct(pred_correct), .label_miss(label_miss),
    .frame_err(frame_err), .img_count(img_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] bits;
    bit         has_lbl;
    logic [3:0] lbl;
    logic [3:0] e_label;
    bit         e_multi;
    bit         e_correct;
    bit         e_miss;
  } vec_t;

  typedef struct {
    logic [3:0] label;
    bit         multi;
    bit         correct;
    bit         miss;
    int         img;
    int         err;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   rep_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_img = 0;
  int   m_err = 0;
  int   ferr_seen = 0;
  int   ferr_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rep(input logic [3:0] l, input bit m, input bit c, input bit ms, input bit clr);
    exp_t e;
    if (clr) begin
      m_img = 0;
      m_err = 0;
    end else begin
      if (m_img < CNT_MAX) m_img++;
      if (!c && m_err < CNT_MAX) m_err++;
    end
    e.label = l; e.multi = m; e.correct = c; e.miss = ms;
    e.img = STATS ? m_img : 0;
    e.err = STATS ? m_err : 0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_label(input logic [3:0] l);
    label_valid = 1'b1;
    label_in = l;
    @(posedge clk); #1;
    label_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [9:0] bits, input bit keep_valid, input bit clr_last);
    for (int i = 0; i < 10; i++) begin
      result_spike_valid = 1'b1;
      result_spike = bits[i];
      stats_clr = clr_last && (i == 9);
      @(posedge clk); #1;
    end
    stats_clr = 1'b0;
    chk("report_latency", pred_valid, 1);
    if (!keep_valid) begin
      result_spike_valid = 1'b0;
      result_spike = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pred_label"}, pred_label, 4'hF);
    chk({tag, "_pred_valid"}, pred_valid, 0);
    chk({tag, "_pred_multi"}, pred_multi, 0);
    chk({tag, "_pred_correct"}, pred_correct, 0);
    chk({tag, "_label_miss"}, label_miss, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_label_ready"}, label_ready, 1);
    chk({tag, "_img_count"}, img_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (pred_valid) begin
        rep_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_report: got pred_label %0h with no report expected", pred_label);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pred_label", pred_label, e.label);
          chk("pred_multi", pred_multi, e.multi);
          chk("pred_correct", pred_correct, e.correct);
          chk("label_miss", label_miss, e.miss);
          chk("img_count", img_count, e.img);
          chk("err_count", err_count, e.err);
        end
      end
      if (frame_err) ferr_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within 200000");
    $fatal(1);
  end

  initial begin
    int n;
    //            bits           lbl?  lbl    exp   multi corr miss
    vecs[0] = '{10'b0000100000, 1'b1, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{10'b0010001000, 1'b1, 4'd7, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{10'b0000000000, 1'b1, 4'd2, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{10'b0000000001, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{10'b1000000000, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{10'b1111111111, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{10'b1100000000, 1'b1, 4'd8, 4'd8, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{10'b0000010000, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1};

    idle(2);
    check_reset_state("reset");
    rst = 1'b0;
    idle(1);

    foreach (vecs[k]) begin
      if (vecs[k].has_lbl) push_label(vecs[k].lbl);
      expect_rep(vecs[k].e_label, vecs[k].e_multi, vecs[k].e_correct, vecs[k].e_miss, 1'b0);
      send_frame(vecs[k].bits, 1'b0, 1'b0);
      idle(1);
    end

    // stats_clr in the report cycle wins over the increment
    push_label(4'd2);
    expect_rep(4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(10'b0000000100, 1'b0, 1'b1);
    idle(1);
    expect_rep(4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(10'b0000000010, 1'b0, 1'b0);
    idle(1);

    // truncated frame: six bits then valid drops
    push_label(4'd6);
    for (int i = 0; i < 6; i++) begin
      result_spike_valid = 1'b1;
      result_spike = (i == 3);
      @(posedge clk); #1;
    end
    result_spike_valid = 1'b0;
    result_spike = 1'b0;
    @(posedge clk); #1;
    ferr_exp++;
    chk("trunc_frame_err", frame_err, 1);
    chk("trunc_no_report", pred_valid, 0);
    @(posedge clk); #1;
    chk("trunc_frame_err_pulse", frame_err, 0);
    expect_rep(4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(10'b0001000000, 1'b0, 1'b0);
    idle(1);

    // back-to-back frames with an empty FIFO
    expect_rep(4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_rep(4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(10'b0000000010, 1'b1, 1'b0);
    send_frame(10'b0000000100, 1'b0, 1'b0);
    idle(2);
    n = rep_cyc.size();
    if (n >= 2) chk("b2b_spacing", rep_cyc[n-1] - rep_cyc[n-2], 10);
    else chk("b2b_report_count", n, 2);

    // fill FIFO beyond depth; the fifth label must be dropped
    for (int k = 1; k <= 5; k++) begin
      push_label(4'(k));
      chk($sformatf("label_ready_after_push%0d", k), label_ready, (k < 4) ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      expect_rep(4'(k), 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(10'(1 << k), 1'b0, 1'b0);
      if (k == 1) chk("label_ready_after_pop", label_ready, 1);
      idle(1);
    end
    expect_rep(4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(10'b0000100000, 1'b0, 1'b0);
    idle(1);

    // reset mid-frame discards frame, FIFO and counters
    push_label(4'd7);
    for (int i = 0; i < 3; i++) begin
      result_spike_valid = 1'b1;
      result_spike = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    result_spike_valid = 1'b0;
    result_spike = 1'b0;
    sb.delete();
    m_img = 0;
    m_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    expect_rep(4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(10'b0010000000, 1'b0, 1'b0);
    idle(3);

    chk("pending_reports", sb.size(), 0);
    chk("frame_err_pulses", ferr_seen, ferr_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
